mm_control_fsm: RTL and testbench

Multicycle control sequencer for the memory-to-memory CPU datapath (`stage_5`). It reads the latched opcode (`OPOut`) and steps one instruction at a time through fetch, operand-address fetch, operand load, execute and write-back. In each state it drives every select and write-enable input of `stage_5`. Branch resolution stays in the datapath: this block raises `branch`, and `stage_5` gates that with its internal `isTrue`.

---
 rtl/mm_ctrl_pkg.sv | 70 +++++++
 rtl/mm_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_mm_control_fsm.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_ctrl_pkg.sv
// Shared encodings for the memory-to-memory CPU control sequencer:
// FSM states, opcode values, ALU function codes and datapath mux selects.
package mm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR_A = 4'd3,
    S_ADDR_B = 4'd4,
    S_ADDR_D = 4'd5,
    S_LOAD_A = 4'd6,
    S_LOAD_B = 4'd7,
    S_WRITE  = 4'd8,
    S_CMP    = 4'd9,
    S_JUMP   = 4'd10,
    S_WR_IO  = 4'd11,
    S_HALT   = 4'd12
  } ctrlState;

  // Instruction families that share a path through the FSM.
  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_BEQ  = 3'd1,
    CLS_JMP  = 3'd2,
    CLS_IN   = 3'd3,
    CLS_HALT = 3'd4
  } opClass;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_IN   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_EQ  = 4'b1000;

  localparam logic [1:0] MA_PC   = 2'b00;
  localparam logic [1:0] MA_A    = 2'b01;
  localparam logic [1:0] MA_B    = 2'b10;
  localparam logic [1:0] MA_DEST = 2'b11;

  localparam logic [1:0] MWD_ALU = 2'b00;
  localparam logic [1:0] MWD_IO  = 2'b01;

  localparam logic [1:0] SA_PC = 2'b00;
  localparam logic [1:0] SA_A  = 2'b01;

  localparam logic [1:0] SB_ONE = 2'b00;
  localparam logic [1:0] SB_B   = 2'b01;

  // Map an opcode to its instruction family; anything undefined halts.
  function automatic opClass classifyOp(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_ALU;
      OP_BEQ:                        return CLS_BEQ;
      OP_JMP:                        return CLS_JMP;
      OP_IN:                         return CLS_IN;
      default:                       return CLS_HALT;
    endcase
  endfunction

endpackage

// File: rtl/mm_control_fsm.sv
// Multicycle control sequencer for the stage_5 memory-to-memory datapath.
// Steps one instruction through fetch, operand-address fetch, operand load,
// execute and write-back; every output is a decode of the registered state.
module mm_control_fsm #(
  parameter int OPC_W = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] OPOut,
  output logic       inputPC,
  output logic       regOrPC,
  output logic       valA,
  output logic       branch,
  output logic [1:0] memAddr,
  output logic [1:0] memWriteData,
  output logic [1:0] ALUsrca,
  output logic [1:0] ALUsrcb,
  output logic [3:0] ALUOp,
  output logic       writeOp,
  output logic       writeA,
  output logic       writeB,
  output logic       writeDest,
  output logic       writePC,
  output logic       writeMem,
  output logic       halted,
  output logic       busy
);
  import mm_ctrl_pkg::*;

  ctrlState state;
  ctrlState nextState;
  logic [3:0] opc;
  opClass     cls;
  logic       unusedOpLow;

  assign opc         = 4'(OPOut[7 -: OPC_W]);
  assign cls         = classifyOp(opc);
  assign unusedOpLow = ^OPOut[3:0];

  assign regOrPC = 1'b0;
  assign valA    = 1'b0;

  // State register: reset drops any instruction in flight back to IDLE.
  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= nextState;
  end

  // Next-state logic: run is only consulted at instruction boundaries.
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:   if (run) nextState = S_FETCH;
      S_FETCH:  nextState = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_ALU, CLS_BEQ: nextState = S_ADDR_A;
          CLS_JMP, CLS_IN:  nextState = S_ADDR_D;
          default:          nextState = S_HALT;
        endcase
      end
      S_ADDR_A: nextState = S_ADDR_B;
      S_ADDR_B: nextState = S_ADDR_D;
      S_ADDR_D: begin
        case (cls)
          CLS_ALU, CLS_BEQ: nextState = S_LOAD_A;
          CLS_JMP:          nextState = S_JUMP;
          CLS_IN:           nextState = S_WR_IO;
          default:          nextState = S_HALT;
        endcase
      end
      S_LOAD_A: nextState = S_LOAD_B;
      S_LOAD_B: begin
        case (cls)
          CLS_ALU: nextState = S_WRITE;
          CLS_BEQ: nextState = S_CMP;
          default: nextState = S_HALT;
        endcase
      end
      S_WRITE, S_CMP, S_JUMP, S_WR_IO: nextState = run ? S_FETCH : S_IDLE;
      S_HALT:   nextState = S_HALT;
      default:  nextState = S_IDLE;
    endcase
  end

  // Output decode: Moore outputs per state, write enables suppressed while reset is high.
  always_comb begin
    inputPC      = 1'b0;
    branch       = 1'b0;
    memAddr      = MA_PC;
    memWriteData = MWD_ALU;
    ALUsrca      = SA_PC;
    ALUsrcb      = SB_ONE;
    ALUOp        = ALU_ADD;
    writeOp      = 1'b0;
    writeA       = 1'b0;
    writeB       = 1'b0;
    writeDest    = 1'b0;
    writePC      = 1'b0;
    writeMem     = 1'b0;
    halted       = 1'b0;
    busy         = 1'b1;
    case (state)
      S_IDLE: busy = 1'b0;
      S_FETCH: begin
        memAddr = MA_PC;
        ALUsrca = SA_PC;
        ALUsrcb = SB_ONE;
        ALUOp   = ALU_ADD;
        writeOp = 1'b1;
        writePC = 1'b1;
      end
      S_DECODE: ;
      S_ADDR_A: begin
        writeA  = 1'b1;
        writePC = 1'b1;
      end
      S_ADDR_B: begin
        writeB  = 1'b1;
        writePC = 1'b1;
      end
      S_ADDR_D: begin
        writeDest = 1'b1;
        writePC   = 1'b1;
      end
      S_LOAD_A: begin
        memAddr = MA_A;
        writeA  = 1'b1;
      end
      S_LOAD_B: begin
        memAddr = MA_B;
        writeB  = 1'b1;
      end
      S_WRITE: begin
        ALUsrca      = SA_A;
        ALUsrcb      = SB_B;
        ALUOp        = {2'b00, opc[1:0]};
        memAddr      = MA_DEST;
        memWriteData = MWD_ALU;
        writeMem     = 1'b1;
      end
      S_CMP: begin
        ALUsrca = SA_A;
        ALUsrcb = SB_B;
        ALUOp   = ALU_EQ;
        inputPC = 1'b1;
        branch  = 1'b1;
      end
      S_JUMP: begin
        inputPC = 1'b1;
        writePC = 1'b1;
      end
      S_WR_IO: begin
        memAddr      = MA_DEST;
        memWriteData = MWD_IO;
        writeMem     = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
        busy   = 1'b0;
      end
      default: busy = 1'b0;
    endcase
    if (reset) begin
      writeOp   = 1'b0;
      writeA    = 1'b0;
      writeB    = 1'b0;
      writeDest = 1'b0;
      writePC   = 1'b0;
      writeMem  = 1'b0;
      branch    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mm_control_fsm.sv
// Bench for mm_control_fsm: a small behavioural stage_5 datapath runs real
// programs, per-cycle control words are queued and checked by a monitor.
module tb_mm_control_fsm;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] OPOut;
  logic       inputPC, regOrPC, valA, branch;
  logic [1:0] memAddr, memWriteData, ALUsrca, ALUsrcb;
  logic [3:0] ALUOp;
  logic       writeOp, writeA, writeB, writeDest, writePC, writeMem;
  logic       halted, busy;

  mm_control_fsm #(.OPC_W(4)) dut (
    .CLK(CLK), .reset(reset), .run(run), .OPOut(OPOut),
    .inputPC(inputPC), .regOrPC(regOrPC), .valA(valA), .branch(branch),
    .memAddr(memAddr), .memWriteData(memWriteData),
    .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb), .ALUOp(ALUOp),
    .writeOp(writeOp), .writeA(writeA), .writeB(writeB),
    .writeDest(writeDest), .writePC(writePC), .writeMem(writeMem),
    .halted(halted), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Control word packing: {inputPC,regOrPC,valA,branch,memAddr,memWriteData,
  // ALUsrca,ALUsrcb,ALUOp,we{Op,A,B,Dest,PC,Mem},halted,busy}
  function automatic logic [23:0] cw(input logic ipc, input logic br,
                                     input logic [1:0] ma, input logic [1:0] mwd,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [3:0] op, input logic [5:0] we,
                                     input logic hlt, input logic bsy);
    return {ipc, 1'b0, 1'b0, br, ma, mwd, sa, sb, op, we, hlt, bsy};
  endfunction

  localparam logic [23:0] V_IDLE   = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b000000, 0, 0);
  localparam logic [23:0] V_FETCH  = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b100010, 0, 1);
  localparam logic [23:0] V_DECODE = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b000000, 0, 1);
  localparam logic [23:0] V_ADDR_A = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b010010, 0, 1);
  localparam logic [23:0] V_ADDR_B = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b001010, 0, 1);
  localparam logic [23:0] V_ADDR_D = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b000110, 0, 1);
  localparam logic [23:0] V_LOAD_A = cw(0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 6'b010000, 0, 1);
  localparam logic [23:0] V_LOAD_B = cw(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0, 6'b001000, 0, 1);
  localparam logic [23:0] V_LDB_RS = cw(0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'h0, 6'b000000, 0, 1);
  localparam logic [23:0] V_WR_ADD = cw(0, 0, 2'b11, 2'b00, 2'b01, 2'b01, 4'h0, 6'b000001, 0, 1);
  localparam logic [23:0] V_WR_SUB = cw(0, 0, 2'b11, 2'b00, 2'b01, 2'b01, 4'h1, 6'b000001, 0, 1);
  localparam logic [23:0] V_CMP    = cw(1, 1, 2'b00, 2'b00, 2'b01, 2'b01, 4'h8, 6'b000000, 0, 1);
  localparam logic [23:0] V_JUMP   = cw(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b000010, 0, 1);
  localparam logic [23:0] V_WR_IO  = cw(0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 4'h0, 6'b000001, 0, 1);
  localparam logic [23:0] V_HALT   = cw(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 6'b000000, 1, 0);

  // Behavioural stage_5 datapath
  logic [7:0] mem [0:255];
  logic [7:0] img [0:255];
  logic [7:0] PC, A, B, Dest, OP;
  logic [7:0] ioInput = 8'h5A;
  logic       dpClear = 1'b0;
  int         wmCount, brCount;
  logic [7:0] aluA, aluB, aluOut, addr, rdata;
  logic       isTrue;

  assign OPOut = OP;

  always_comb begin
    aluA = (ALUsrca == 2'b01) ? A : PC;
    aluB = (ALUsrcb == 2'b01) ? B : 8'd1;
    case (ALUOp)
      4'h0:    aluOut = aluA + aluB;
      4'h1:    aluOut = aluA - aluB;
      4'h2:    aluOut = aluA & aluB;
      4'h3:    aluOut = aluA | aluB;
      4'h8:    aluOut = {7'd0, aluA == aluB};
      default: aluOut = 8'h00;
    endcase
    isTrue = (aluA == aluB);
    case (memAddr)
      2'b00:   addr = PC;
      2'b01:   addr = A;
      2'b10:   addr = B;
      default: addr = Dest;
    endcase
    rdata = mem[addr];
  end

  always @(posedge CLK) begin
    if (dpClear) begin
      mem <= img;
      PC <= 8'h00; A <= 8'h00; B <= 8'h00; Dest <= 8'h00; OP <= 8'h00;
      wmCount <= 0; brCount <= 0;
    end else begin
      if (writeOp)   OP   <= rdata;
      if (writeA)    A    <= rdata;
      if (writeB)    B    <= rdata;
      if (writeDest) Dest <= rdata;
      if (writeMem) begin
        mem[addr] <= (memWriteData == 2'b01) ? ioInput : aluOut;
        wmCount <= wmCount + 1;
      end
      if (branch) brCount <= brCount + 1;
      if (writePC || (branch && isTrue)) PC <= inputPC ? Dest : aluOut;
    end
  end

  // Scoreboard
  logic [23:0] expQ [$];
  string       tagQ [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic pushExp(input logic [23:0] v, input string name);
    expQ.push_back(v);
    tagQ.push_back(name);
  endtask

  always @(negedge CLK) begin
    if (expQ.size() != 0) begin
      logic [23:0] want;
      string       name;
      want = expQ.pop_front();
      name = tagQ.pop_front();
      chk(name, {8'h00, inputPC, regOrPC, valA, branch, memAddr, memWriteData,
                 ALUsrca, ALUsrcb, ALUOp, writeOp, writeA, writeB, writeDest,
                 writePC, writeMem, halted, busy},
          {8'h00, want});
    end
  end

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", expQ.size());
      expQ.delete();
      tagQ.delete();
    end
  endtask

  task automatic clearImg();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // One reset cycle that also loads the program image; leaves FSM in IDLE.
  task automatic loadAndReset();
    reset = 1'b1; dpClear = 1'b1; run = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b0; dpClear = 1'b0;
  endtask

  task automatic pushAluFront();
    pushExp(V_IDLE, "idle0");    pushExp(V_FETCH, "fetch");
    pushExp(V_DECODE, "decode"); pushExp(V_ADDR_A, "addrA");
    pushExp(V_ADDR_B, "addrB");  pushExp(V_ADDR_D, "addrD");
    pushExp(V_LOAD_A, "loadA");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clearImg();
    // Reset state
    @(posedge CLK); #1;
    pushExp(V_IDLE, "resetIdle");
    drain();

    // ADD M[12]=M[10]+M[11], run dropped during ADDR_B
    clearImg();
    img[0] = 8'h00; img[1] = 8'd10; img[2] = 8'd11; img[3] = 8'd12;
    img[10] = 8'd3; img[11] = 8'd4;
    loadAndReset();
    pushAluFront();
    pushExp(V_LOAD_B, "loadB"); pushExp(V_WR_ADD, "writeAdd");
    pushExp(V_IDLE, "addIdle");
    run = 1'b1;
    repeat (4) begin @(posedge CLK); #1; end
    run = 1'b0;
    drain();
    chk("addResult", {24'd0, mem[12]}, 32'd7);
    chk("addPC", {24'd0, PC}, 32'd4);
    chk("addWriteMemCount", wmCount, 32'd1);

    // BEQ taken
    clearImg();
    img[0] = 8'h80; img[1] = 8'd10; img[2] = 8'd11; img[3] = 8'h20;
    img[10] = 8'd5; img[11] = 8'd5;
    loadAndReset();
    pushAluFront();
    pushExp(V_LOAD_B, "loadB"); pushExp(V_CMP, "cmp"); pushExp(V_IDLE, "beqIdle");
    run = 1'b1;
    @(posedge CLK); #1;
    run = 1'b0;
    drain();
    chk("beqTakenPC", {24'd0, PC}, 32'h20);
    chk("beqBranchCount", brCount, 32'd1);

    // BEQ not taken
    img[11] = 8'd6;
    loadAndReset();
    pushAluFront();
    pushExp(V_LOAD_B, "loadB"); pushExp(V_CMP, "cmp"); pushExp(V_IDLE, "beqIdle");
    run = 1'b1;
    @(posedge CLK); #1;
    run = 1'b0;
    drain();
    chk("beqNotTakenPC", {24'd0, PC}, 32'd4);

    // JMP 0x30
    clearImg();
    img[0] = 8'hC0; img[1] = 8'h30;
    loadAndReset();
    pushExp(V_IDLE, "idle0"); pushExp(V_FETCH, "fetch"); pushExp(V_DECODE, "decode");
    pushExp(V_ADDR_D, "addrD"); pushExp(V_JUMP, "jump"); pushExp(V_IDLE, "jmpIdle");
    run = 1'b1;
    @(posedge CLK); #1;
    run = 1'b0;
    drain();
    chk("jmpPC", {24'd0, PC}, 32'h30);

    // IN to M[0x40]
    clearImg();
    img[0] = 8'hE0; img[1] = 8'h40;
    loadAndReset();
    pushExp(V_IDLE, "idle0"); pushExp(V_FETCH, "fetch"); pushExp(V_DECODE, "decode");
    pushExp(V_ADDR_D, "addrD"); pushExp(V_WR_IO, "wrIo"); pushExp(V_IDLE, "inIdle");
    run = 1'b1;
    @(posedge CLK); #1;
    run = 1'b0;
    drain();
    chk("inResult", {24'd0, mem[8'h40]}, 32'h5A);

    // SUB followed directly by HALT with run held high
    clearImg();
    img[0] = 8'h10; img[1] = 8'd10; img[2] = 8'd11; img[3] = 8'd12; img[4] = 8'hF0;
    img[10] = 8'd9; img[11] = 8'd4;
    loadAndReset();
    pushAluFront();
    pushExp(V_LOAD_B, "loadB"); pushExp(V_WR_SUB, "writeSub");
    pushExp(V_FETCH, "fetch2"); pushExp(V_DECODE, "decode2");
    pushExp(V_HALT, "halt0"); pushExp(V_HALT, "halt1");
    run = 1'b1;
    drain();
    chk("subResult", {24'd0, mem[12]}, 32'd5);

    // Undefined opcode 0x5 halts and stays quiet with run high
    clearImg();
    img[0] = 8'h50;
    loadAndReset();
    pushExp(V_IDLE, "idle0"); pushExp(V_FETCH, "fetch"); pushExp(V_DECODE, "decode");
    for (int i = 0; i < 20; i++) pushExp(V_HALT, "undefHalt");
    run = 1'b1;
    drain();
    chk("undefWriteMemCount", wmCount, 32'd0);

    // Reset during LOAD_B of an ADD abandons it
    clearImg();
    img[0] = 8'h00; img[1] = 8'd10; img[2] = 8'd11; img[3] = 8'd12;
    img[10] = 8'd3; img[11] = 8'd4;
    loadAndReset();
    pushAluFront();
    pushExp(V_LDB_RS, "loadBReset");
    pushExp(V_IDLE, "postResetIdle"); pushExp(V_IDLE, "postResetIdle2");
    run = 1'b1;
    repeat (7) begin @(posedge CLK); #1; end
    reset = 1'b1; run = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b0;
    drain();
    chk("resetWriteMemCount", wmCount, 32'd0);
    chk("resetDestUntouched", {24'd0, mem[12]}, 32'd0);
    chk("resetBNotLoaded", {24'd0, B}, 32'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
